// File: rtl/lab7_3_time_keeper_if.sv
// rtl/lab7_3_time_keeper_if.sv - set-time inputs and running-time outputs of the time keeper
`timescale 1ns/1ps
interface lab7_3_time_keeper_if;
  logic       set;
  logic       pause;
  logic [3:0] f_h1;
  logic [3:0] f_h2;
  logic [3:0] f_m1;
  logic [3:0] f_m2;
  logic [3:0] t_h1;
  logic [3:0] t_h2;
  logic [3:0] t_m1;
  logic [3:0] t_m2;
  logic [3:0] t_s1;
  logic [3:0] t_s2;
  logic       min_pulse;
  logic       day_pulse;
  logic       load_err;
  logic       running;

  // upstream set-time block and downstream consumers
  modport master (
    output set, pause, f_h1, f_h2, f_m1, f_m2,
    input  t_h1, t_h2, t_m1, t_m2, t_s1, t_s2,
    input  min_pulse, day_pulse, load_err, running
  );

  // the time keeper itself
  modport slave (
    input  set, pause, f_h1, f_h2, f_m1, f_m2,
    output t_h1, t_h2, t_m1, t_m2, t_s1, t_s2,
    output min_pulse, day_pulse, load_err, running
  );
endinterface

// File: rtl/lab7_3_time_keeper.sv
// rtl/lab7_3_time_keeper.sv - 24-hour BCD time-of-day counter with set/load/pause control
`timescale 1ns/1ps
module lab7_3_time_keeper #(
  parameter int TICK_DIV = 1
) (
  input  logic                  clk_1,
  input  logic                  rst_n,
  lab7_3_time_keeper_if.slave   tk
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE
  } state_t;

  localparam logic [9:0] DIV_LAST = 10'(TICK_DIV - 1);

  state_t     state;
  state_t     state_nxt;
  logic [9:0] presc;
  logic [3:0] h1, h2, m1, m2, s1, s2;
  logic       min_p, day_p, err_p;

  logic load_ok;
  logic do_load;
  logic advance;
  logic tick;
  logic s2_wrap, s1_wrap, m2_wrap, m1_wrap, h2_wrap, hour_wrap;
  logic carry_m2, carry_m1, carry_h;

  // hours 20..23 are the only legal values with a tens digit of 2
  assign load_ok = (tk.f_h1 <= 4'd2) && (tk.f_h2 <= 4'd9) &&
                   (tk.f_m1 <= 4'd5) && (tk.f_m2 <= 4'd9) &&
                   !((tk.f_h1 == 4'd2) && (tk.f_h2 > 4'd3));
  assign do_load = (state == ST_LOAD) && load_ok;

  // set and pause both pre-empt counting on the cycle they are seen in RUN
  assign advance = (state == ST_RUN) && !tk.set && !tk.pause;
  assign tick    = advance && (presc == DIV_LAST);

  assign s2_wrap   = (s2 == 4'd9);
  assign s1_wrap   = (s1 == 4'd5);
  assign m2_wrap   = (m2 == 4'd9);
  assign m1_wrap   = (m1 == 4'd5);
  assign h2_wrap   = (h2 == 4'd9);
  assign hour_wrap = (h1 == 4'd2) && (h2 == 4'd3);
  assign carry_m2  = s2_wrap && s1_wrap;
  assign carry_m1  = carry_m2 && m2_wrap;
  assign carry_h   = carry_m1 && m1_wrap;

  // state register
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state selection, set has priority over pause everywhere
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (tk.set) state_nxt = ST_SET;
                else if (!tk.pause) state_nxt = ST_RUN;
      ST_SET:   if (!tk.set) state_nxt = ST_LOAD;
      ST_LOAD:  if (tk.set) state_nxt = ST_SET;
                else if (tk.pause) state_nxt = ST_PAUSE;
                else state_nxt = ST_RUN;
      ST_RUN:   if (tk.set) state_nxt = ST_SET;
                else if (tk.pause) state_nxt = ST_PAUSE;
      ST_PAUSE: if (tk.set) state_nxt = ST_SET;
                else if (!tk.pause) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // prescaler: cleared while setting and on a good load, held whenever not advancing
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n)                        presc <= '0;
    else if (state == ST_SET || do_load) presc <= '0;
    else if (advance)                  presc <= tick ? 10'd0 : presc + 10'd1;
  end

  // time digits: load from the set block or ripple the one-second carry
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      {h1, h2, m1, m2, s1, s2} <= '0;
    end else if (do_load) begin
      h1 <= tk.f_h1;
      h2 <= tk.f_h2;
      m1 <= tk.f_m1;
      m2 <= tk.f_m2;
      s1 <= 4'd0;
      s2 <= 4'd0;
    end else if (tick) begin
      s2 <= s2_wrap ? 4'd0 : s2 + 4'd1;
      if (s2_wrap)  s1 <= s1_wrap ? 4'd0 : s1 + 4'd1;
      if (carry_m2) m2 <= m2_wrap ? 4'd0 : m2 + 4'd1;
      if (carry_m1) m1 <= m1_wrap ? 4'd0 : m1 + 4'd1;
      if (carry_h) begin
        if (hour_wrap) begin
          h1 <= 4'd0;
          h2 <= 4'd0;
        end else if (h2_wrap) begin
          h1 <= h1 + 4'd1;
          h2 <= 4'd0;
        end else begin
          h2 <= h2 + 4'd1;
        end
      end
    end
  end

  // strobes line up with the first cycle the wrapped value is visible
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      min_p <= 1'b0;
      day_p <= 1'b0;
      err_p <= 1'b0;
    end else begin
      min_p <= tick && carry_m2;
      day_p <= tick && carry_h && hour_wrap;
      err_p <= (state == ST_LOAD) && !load_ok;
    end
  end

  assign tk.t_h1      = h1;
  assign tk.t_h2      = h2;
  assign tk.t_m1      = m1;
  assign tk.t_m2      = m2;
  assign tk.t_s1      = s1;
  assign tk.t_s2      = s2;
  assign tk.min_pulse = min_p;
  assign tk.day_pulse = day_p;
  assign tk.load_err  = err_p;
  assign tk.running   = (state == ST_RUN);

endmodule

// File: tb/tb_lab7_3_time_keeper.sv
// tb/tb_lab7_3_time_keeper.sv - self-checking bench for lab7_3_time_keeper
`timescale 1ns/1ps
module tb_lab7_3_time_keeper;

  localparam int M_IDLE = 0, M_SET = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4;

  typedef struct {
    int mode;
    int secs;
    int presc;
    bit minp;
    bit dayp;
    bit lerr;
  } mdl_t;

  logic clk_1 = 1'b0;
  logic rst_n = 1'b0;
  logic set = 1'b0, pause = 1'b0;
  logic [3:0] f_h1 = '0, f_h2 = '0, f_m1 = '0, f_m2 = '0;
  int vectors = 0;
  int miscompares = 0;
  mdl_t ma, mb;

  always #5 clk_1 = ~clk_1;

  lab7_3_time_keeper_if ifa();
  lab7_3_time_keeper_if ifb();

  assign ifa.set = set;  assign ifa.pause = pause;
  assign ifa.f_h1 = f_h1; assign ifa.f_h2 = f_h2; assign ifa.f_m1 = f_m1; assign ifa.f_m2 = f_m2;
  assign ifb.set = set;  assign ifb.pause = pause;
  assign ifb.f_h1 = f_h1; assign ifb.f_h2 = f_h2; assign ifb.f_m1 = f_m1; assign ifb.f_m2 = f_m2;

  lab7_3_time_keeper #(.TICK_DIV(1)) dut_a (.clk_1(clk_1), .rst_n(rst_n), .tk(ifa));
  lab7_3_time_keeper #(.TICK_DIV(4)) dut_b (.clk_1(clk_1), .rst_n(rst_n), .tk(ifb));

  wire [27:0] got_a = {ifa.t_h1, ifa.t_h2, ifa.t_m1, ifa.t_m2, ifa.t_s1, ifa.t_s2,
                       ifa.min_pulse, ifa.day_pulse, ifa.load_err, ifa.running};
  wire [27:0] got_b = {ifb.t_h1, ifb.t_h2, ifb.t_m1, ifb.t_m2, ifb.t_s1, ifb.t_s2,
                       ifb.min_pulse, ifb.day_pulse, ifb.load_err, ifb.running};

  // expected output word from plain hours/minutes/seconds numbers
  function automatic logic [27:0] tvec(input int h, input int m, input int s,
                                       input bit mp, input bit dp, input bit le, input bit run);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            mp, dp, le, run};
  endfunction

  function automatic logic [27:0] mdl_vec(input mdl_t m);
    return tvec(m.secs / 3600, (m.secs / 60) % 60, m.secs % 60,
                m.minp, m.dayp, m.lerr, m.mode == M_RUN);
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = M_IDLE; m.secs = 0; m.presc = 0;
    m.minp = 0; m.dayp = 0; m.lerr = 0;
    return m;
  endfunction

  // one clock of the time keeper, time held as seconds since midnight
  function automatic mdl_t mdl_step(input mdl_t m, input int div);
    mdl_t n = m;
    int hrs = int'(f_h1) * 10 + int'(f_h2);
    bit ok = (f_h2 <= 9) && (f_m1 <= 5) && (f_m2 <= 9) && (hrs <= 23);
    n.minp = 0; n.dayp = 0; n.lerr = 0;
    case (m.mode)
      M_IDLE:  if (set) n.mode = M_SET; else if (!pause) n.mode = M_RUN;
      M_SET: begin
        n.presc = 0;
        if (!set) n.mode = M_LOAD;
      end
      M_LOAD: begin
        if (ok) begin
          n.secs = hrs * 3600 + (int'(f_m1) * 10 + int'(f_m2)) * 60;
          n.presc = 0;
        end else n.lerr = 1;
        n.mode = set ? M_SET : (pause ? M_PAUSE : M_RUN);
      end
      M_RUN: begin
        if (set) n.mode = M_SET;
        else if (pause) n.mode = M_PAUSE;
        else if (m.presc == div - 1) begin
          n.presc = 0;
          n.secs = (m.secs + 1) % 86400;
          n.minp = (n.secs % 60) == 0;
          n.dayp = n.secs == 0;
        end else n.presc = m.presc + 1;
      end
      default: if (set) n.mode = M_SET; else if (!pause) n.mode = M_RUN;
    endcase
    return n;
  endfunction

  always @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 1);
      mb = mdl_step(mb, 4);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_1);
      @(negedge clk_1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_1);
    rst_n = 1'b0; set = 1'b0; pause = 1'b0;
    f_h1 = 0; f_h2 = 0; f_m1 = 0; f_m2 = 0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_1);
    rst_n = 1'b0;
    step(2);
    vectors++;
    if (got_a !== 28'h0) begin
      miscompares++; $display("FAIL reset_a got=%h exp=%h", got_a, 28'h0);
    end
    vectors++;
    if (got_b !== 28'h0) begin
      miscompares++; $display("FAIL reset_b got=%h exp=%h", got_b, 28'h0);
    end
  endtask

  task automatic test_count();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 61; i++) begin
      step(1);
      if (ifa.min_pulse) pulses++;
    end
    vectors++;
    if (got_a !== tvec(0, 1, 0, 1, 0, 0, 1)) begin
      miscompares++; $display("FAIL count_minute got=%h exp=%h", got_a, tvec(0, 1, 0, 1, 0, 0, 1));
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++; $display("FAIL count_min_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_load_wrap();
    do_reset();
    set = 1'b1;
    step(2);
    f_h1 = 2; f_h2 = 3; f_m1 = 5; f_m2 = 9; set = 1'b0;
    step(2);
    vectors++;
    if (got_a !== tvec(23, 59, 0, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL load_a got=%h exp=%h", got_a, tvec(23, 59, 0, 0, 0, 0, 1));
    end
    vectors++;
    if (got_b !== tvec(23, 59, 0, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL load_b got=%h exp=%h", got_b, tvec(23, 59, 0, 0, 0, 0, 1));
    end
    step(59);
    vectors++;
    if (got_a !== tvec(23, 59, 59, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL pre_wrap got=%h exp=%h", got_a, tvec(23, 59, 59, 0, 0, 0, 1));
    end
    step(1);
    vectors++;
    if (got_a !== tvec(0, 0, 0, 1, 1, 0, 1)) begin
      miscompares++; $display("FAIL day_wrap got=%h exp=%h", got_a, tvec(0, 0, 0, 1, 1, 0, 1));
    end
    step(1);
    vectors++;
    if (got_a !== tvec(0, 0, 1, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL post_wrap got=%h exp=%h", got_a, tvec(0, 0, 1, 0, 0, 0, 1));
    end
  endtask

  task automatic test_load_err();
    do_reset();
    set = 1'b1; f_h1 = 2; f_h2 = 4; f_m1 = 0; f_m2 = 0;
    step(1);
    set = 1'b0;
    step(2);
    vectors++;
    if (got_a !== tvec(0, 0, 0, 0, 0, 1, 1)) begin
      miscompares++; $display("FAIL err_2400 got=%h exp=%h", got_a, tvec(0, 0, 0, 0, 0, 1, 1));
    end
    step(1);
    vectors++;
    if (got_a !== tvec(0, 0, 1, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL err_once got=%h exp=%h", got_a, tvec(0, 0, 1, 0, 0, 0, 1));
    end
    f_h1 = 1; f_h2 = 2; f_m1 = 7; f_m2 = 4'hA; set = 1'b1;
    step(1);
    set = 1'b0;
    step(2);
    vectors++;
    if (got_a !== tvec(0, 0, 1, 0, 0, 1, 1)) begin
      miscompares++; $display("FAIL err_127a got=%h exp=%h", got_a, tvec(0, 0, 1, 0, 0, 1, 1));
    end
  endtask

  task automatic test_pause();
    do_reset();
    step(6);
    vectors++;
    if (got_b !== tvec(0, 0, 1, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL pause_start got=%h exp=%h", got_b, tvec(0, 0, 1, 0, 0, 0, 1));
    end
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      vectors++;
      if (ifb.t_s2 !== 4'd1) begin
        miscompares++; $display("FAIL pause_hold got=%0d exp=1", ifb.t_s2);
      end
    end
    pause = 1'b0;
    step(3);
    vectors++;
    if (got_b !== tvec(0, 0, 1, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL pause_mid got=%h exp=%h", got_b, tvec(0, 0, 1, 0, 0, 0, 1));
    end
    step(1);
    vectors++;
    if (got_b !== tvec(0, 0, 2, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL pause_resume got=%h exp=%h", got_b, tvec(0, 0, 2, 0, 0, 0, 1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set = 1'b1; f_h1 = 1; f_h2 = 3; f_m1 = 4; f_m2 = 5;
    step(1);
    set = 1'b0;
    step(29);
    vectors++;
    if (got_a !== tvec(13, 45, 27, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL mid_time got=%h exp=%h", got_a, tvec(13, 45, 27, 0, 0, 0, 1));
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (got_a !== 28'h0) begin
      miscompares++; $display("FAIL async_reset got=%h exp=%h", got_a, 28'h0);
    end
    @(negedge clk_1);
    vectors++;
    if (got_a !== 28'h0) begin
      miscompares++; $display("FAIL reset_hold got=%h exp=%h", got_a, 28'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_set_on_tick();
    do_reset();
    step(60);
    vectors++;
    if (got_a !== tvec(0, 0, 59, 0, 0, 0, 1)) begin
      miscompares++; $display("FAIL tick_pre got=%h exp=%h", got_a, tvec(0, 0, 59, 0, 0, 0, 1));
    end
    set = 1'b1;
    step(1);
    vectors++;
    if (got_a !== tvec(0, 0, 59, 0, 0, 0, 0)) begin
      miscompares++; $display("FAIL set_on_tick got=%h exp=%h", got_a, tvec(0, 0, 59, 0, 0, 0, 0));
    end
    step(2);
    vectors++;
    if (got_a !== tvec(0, 0, 59, 0, 0, 0, 0)) begin
      miscompares++; $display("FAIL set_frozen got=%h exp=%h", got_a, tvec(0, 0, 59, 0, 0, 0, 0));
    end
    set = 1'b0;
    step(1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      set   = ($urandom % 40) == 0;
      pause = ($urandom % 10) < 2;
      if (($urandom % 4) == 0) begin
        f_h1 = 4'($urandom); f_h2 = 4'($urandom); f_m1 = 4'($urandom); f_m2 = 4'($urandom);
      end else if (($urandom % 2) == 0) begin
        f_h1 = 2; f_h2 = 3; f_m1 = 5; f_m2 = 4'($urandom_range(8, 9));
      end else begin
        f_h1 = 4'($urandom_range(0, 2));
        f_h2 = (f_h1 == 2) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9));
        f_m1 = 4'($urandom_range(0, 5)); f_m2 = 4'($urandom_range(0, 9));
      end
      if (($urandom % 700) == 0) rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      vectors++;
      if (got_a !== mdl_vec(ma)) begin
        miscompares++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", i, got_a, mdl_vec(ma));
      end
      vectors++;
      if (got_b !== mdl_vec(mb)) begin
        miscompares++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", i, got_b, mdl_vec(mb));
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_load_wrap();
    test_load_err();
    test_pause();
    test_reset_mid();
    test_set_on_tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
